// File: rtl/bp_be_long_ctrl.sv
// bp_be_long_ctrl: sequencer for the shared iterative long-latency unit.
// It accepts one long op at a time and counts that op's fixed latency.
// It then holds the writeback request until the writeback port takes it.
module bp_be_long_ctrl #(
  parameter int unsigned idiv_cycles_p    = 64,
  parameter int unsigned fdiv_cycles_p    = 56,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,

  input  logic                        req_v_i,
  input  logic                        req_fp_i,
  input  logic [reg_addr_width_p-1:0] req_rd_addr_i,
  output logic                        req_ready_o,

  output logic                        unit_start_o,
  output logic                        unit_fp_o,

  output logic                        wb_v_o,
  output logic                        wb_fp_o,
  output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
  input  logic                        wb_yumi_i,

  output logic                        long_busy_o
);

  localparam int unsigned max_cycles_lp =
    (idiv_cycles_p > fdiv_cycles_p) ? idiv_cycles_p : fdiv_cycles_p;
  localparam int unsigned cnt_width_lp =
    (max_cycles_lp > 1) ? $clog2(max_cycles_lp) : 1;

  // The counter is loaded with N-1, so an N-cycle op spends exactly N cycles in BUSY.
  localparam logic [cnt_width_lp-1:0] idiv_load_lp = cnt_width_lp'(idiv_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] fdiv_load_lp = cnt_width_lp'(fdiv_cycles_p - 1);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_busy = 2'd1,
    e_wb   = 2'd2
  } state_e;

  state_e                      state_q;
  logic [cnt_width_lp-1:0]     cnt_q;
  logic                        fp_q;
  logic [reg_addr_width_p-1:0] rd_q;
  logic                        accept;

  // Handshake decode: a flush blocks any accept in the same cycle.
  assign req_ready_o  = (state_q == e_idle) & ~flush_i;
  assign accept       = req_v_i & req_ready_o;
  assign unit_start_o = accept;
  assign unit_fp_o    = req_fp_i;

  // A flush in WB masks the request so that a yumi in the same cycle cannot retire it.
  assign wb_v_o       = (state_q == e_wb) & ~flush_i;
  assign wb_fp_o      = fp_q;
  assign wb_rd_addr_o = rd_q;
  assign long_busy_o  = (state_q != e_idle);

  // Sequencer: the state, the latency down-counter and the captured op info.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        e_idle: begin
          if (accept) begin
            state_q <= e_busy;
            cnt_q   <= req_fp_i ? fdiv_load_lp : idiv_load_lp;
            fp_q    <= req_fp_i;
            rd_q    <= req_rd_addr_i;
          end
        end
        e_busy: begin
          if (flush_i) begin
            state_q <= e_idle;
          end else if (cnt_q == '0) begin
            state_q <= e_wb;
          end else begin
            cnt_q <= cnt_q - cnt_width_lp'(1);
          end
        end
        e_wb: begin
          if (flush_i | wb_yumi_i) begin
            state_q <= e_idle;
          end
        end
        default: state_q <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_long_ctrl.sv
// Testbench for bp_be_long_ctrl.
// Stimulus pushes the expected start pulses and writebacks into queues.
// A negedge monitor pops those queues and compares them with what the DUT presents.
module tb_bp_be_long_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, flush_i;
  logic       req_v_i, req_fp_i, req_ready_o;
  logic [4:0] req_rd_addr_i;
  logic       unit_start_o, unit_fp_o;
  logic       wb_v_o, wb_fp_o, wb_yumi_i, long_busy_o;
  logic [4:0] wb_rd_addr_o;

  // Second instance built with a one-cycle integer divide.
  logic       req_v1, req_fp1, req_ready1, start1, unit_fp1;
  logic [4:0] rd1, wb_rd1;
  logic       wb_v1, wb_fp1, yumi1, busy1;

  typedef struct {
    logic       fp;
    logic [4:0] rd;
    int         cyc;
  } exp_t;

  exp_t st_q[$];
  exp_t wb_q[$];
  exp_t wb1_q[$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_be_long_ctrl u_dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .req_v_i(req_v_i), .req_fp_i(req_fp_i), .req_rd_addr_i(req_rd_addr_i),
    .req_ready_o(req_ready_o), .unit_start_o(unit_start_o), .unit_fp_o(unit_fp_o),
    .wb_v_o(wb_v_o), .wb_fp_o(wb_fp_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_yumi_i(wb_yumi_i), .long_busy_o(long_busy_o)
  );

  bp_be_long_ctrl #(.idiv_cycles_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .flush_i(1'b0),
    .req_v_i(req_v1), .req_fp_i(req_fp1), .req_rd_addr_i(rd1),
    .req_ready_o(req_ready1), .unit_start_o(start1), .unit_fp_o(unit_fp1),
    .wb_v_o(wb_v1), .wb_fp_o(wb_fp1), .wb_rd_addr_o(wb_rd1),
    .wb_yumi_i(yumi1), .long_busy_o(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_st(input logic fp, input int c);
    exp_t e;
    e.fp = fp; e.rd = 5'd0; e.cyc = c;
    st_q.push_back(e);
  endtask

  task automatic push_wb(input logic fp, input logic [4:0] rd, input int c);
    exp_t e;
    e.fp = fp; e.rd = rd; e.cyc = c;
    wb_q.push_back(e);
  endtask

  task automatic push_wb1(input logic [4:0] rd, input int c);
    exp_t e;
    e.fp = 1'b0; e.rd = rd; e.cyc = c;
    wb1_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire start pulses and accepted writebacks against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (unit_start_o) begin
      if (st_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
      else begin
        e = st_q.pop_front();
        chk("start_fp", unit_fp_o, e.fp);
        chk("start_cyc", cyc, e.cyc);
      end
    end
    if (wb_v_o && wb_yumi_i) begin
      if (wb_q.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
      else begin
        e = wb_q.pop_front();
        chk("wb_fp", wb_fp_o, e.fp);
        chk("wb_rd", wb_rd_addr_o, e.rd);
        chk("wb_cyc", cyc, e.cyc);
      end
    end
    if (wb_v1 && yumi1) begin
      if (wb1_q.size() == 0) chk("unexpected_wb1", 32'd1, 32'd0);
      else begin
        e = wb1_q.pop_front();
        chk("wb1_fp", wb_fp1, e.fp);
        chk("wb1_rd", wb_rd1, e.rd);
        chk("wb1_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset_i = 1'b1; flush_i = 1'b0;
    req_v_i = 1'b0; req_fp_i = 1'b0; req_rd_addr_i = 5'd0; wb_yumi_i = 1'b0;
    req_v1 = 1'b0; req_fp1 = 1'b0; rd1 = 5'd0; yumi1 = 1'b1;

    // Reset
    repeat (2) begin
      @(negedge clk);
      chk("rst_wb_v", wb_v_o, 1'b0);
      chk("rst_busy", long_busy_o, 1'b0);
      chk("rst_start", unit_start_o, 1'b0);
    end
    next_cycle();
    reset_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ready", req_ready_o, 1'b1);
      chk("idle_busy", long_busy_o, 1'b0);
      chk("idle_wb_v", wb_v_o, 1'b0);
      next_cycle();
    end

    // Integer op, rd=7, yumi tied high: wb at 65, idle at 66
    t0 = cyc;
    req_v_i = 1'b1; req_fp_i = 1'b0; req_rd_addr_i = 5'd7; wb_yumi_i = 1'b1;
    push_st(1'b0, t0);
    push_wb(1'b0, 5'd7, t0 + 65);
    @(negedge clk);
    chk("int_ready", req_ready_o, 1'b1);
    for (int k = 1; k <= 66; k++) begin
      next_cycle();
      req_v_i = 1'b0;
      @(negedge clk);
      chk("int_busy", long_busy_o, k <= 65);
      chk("int_wb_v", wb_v_o, k == 65);
    end

    // FP op, rd=3, yumi at 62: wb_v over 57..62, idle at 63
    next_cycle();
    t0 = cyc;
    req_v_i = 1'b1; req_fp_i = 1'b1; req_rd_addr_i = 5'd3; wb_yumi_i = 1'b0;
    push_st(1'b1, t0);
    push_wb(1'b1, 5'd3, t0 + 62);
    @(negedge clk);
    for (int k = 1; k <= 63; k++) begin
      next_cycle();
      req_v_i = 1'b0;
      wb_yumi_i = (k == 62);
      @(negedge clk);
      chk("fp_wb_v", wb_v_o, (k >= 57) && (k <= 62));
      chk("fp_busy", long_busy_o, k <= 62);
      if (k >= 57 && k <= 62) begin
        chk("fp_hold_rd", wb_rd_addr_o, 5'd3);
        chk("fp_hold_fp", wb_fp_o, 1'b1);
      end
    end

    // Flush at cycle 20 of an integer op, then a new accept at 21
    next_cycle();
    t0 = cyc;
    req_v_i = 1'b1; req_fp_i = 1'b0; req_rd_addr_i = 5'd12; wb_yumi_i = 1'b1;
    push_st(1'b0, t0);
    @(negedge clk);
    for (int k = 1; k <= 21; k++) begin
      next_cycle();
      req_v_i = 1'b0;
      flush_i = (k == 20);
      if (k == 21) begin
        req_v_i = 1'b1; req_rd_addr_i = 5'd9;
        push_st(1'b0, cyc);
      end
      @(negedge clk);
      chk("fl_busy", long_busy_o, k <= 20);
      chk("fl_ready", req_ready_o, k == 21);
      chk("fl_wb_v", wb_v_o, 1'b0);
    end

    // Flush in WB with yumi high: no writeback may be taken
    for (int k = 1; k <= 66; k++) begin
      next_cycle();
      req_v_i = 1'b0;
      flush_i = (k == 65);
      wb_yumi_i = 1'b1;
      @(negedge clk);
      chk("fwb_wb_v", wb_v_o, 1'b0);
      chk("fwb_busy", long_busy_o, k <= 65);
    end

    // Flush in IDLE blocks an accept
    next_cycle();
    flush_i = 1'b1; req_v_i = 1'b1;
    @(negedge clk);
    chk("fidle_ready", req_ready_o, 1'b0);
    chk("fidle_start", unit_start_o, 1'b0);
    next_cycle();
    flush_i = 1'b0; req_v_i = 1'b0;
    @(negedge clk);
    chk("fidle_busy", long_busy_o, 1'b0);

    // N=1 back-to-back: accepts at 0 and 3, the held request waits through 1..2
    next_cycle();
    t0 = cyc;
    req_v1 = 1'b1; rd1 = 5'd5;
    push_wb1(5'd5, t0 + 2);
    push_wb1(5'd6, t0 + 5);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) next_cycle();
      if (k == 1) rd1 = 5'd6;
      if (k == 4) req_v1 = 1'b0;
      @(negedge clk);
      chk("b2b_ready", req_ready1, (k == 0) || (k == 3) || (k == 6));
      chk("b2b_start", start1, (k == 0) || (k == 3));
      chk("b2b_wb_v", wb_v1, (k == 2) || (k == 5));
      chk("b2b_busy", busy1, (k == 1) || (k == 2) || (k == 4) || (k == 5));
    end

    // Every expected event must have retired
    next_cycle();
    @(negedge clk);
    chk("st_q_empty", st_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("wb1_q_empty", wb1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
